skew_delay_bank: RTL

Multi-channel, runtime-programmable delay buffer. It generalises the single fixed-depth delay FIFO into CHANNELS independent lanes that share one shift enable. Each lane has its own delay (0..DEPTH shifts), a per-lane output-valid flag, a synchronous flush and a configuration port. It sits in front of the systolic array and generates the diagonal input skew, so lane c sees its data c shifts later by default.

---
 rtl/skew_delay_bank_if.sv | 30 +++
 rtl/skew_delay_bank.sv | 108 ++++++++++
 2 files changed

// File: rtl/skew_delay_bank_if.sv
// Bundles the shift, flush, configuration and data signals of skew_delay_bank.
// master drives stimulus and configuration; slave is the delay bank itself.
interface skew_delay_bank_if #(
    parameter int CHANNELS = 8,
    parameter int BITS     = 64,
    parameter int DEPTH    = 8
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DLY_W = $clog2(DEPTH + 1);

    logic                     en;
    logic                     clr;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_ch;
    logic [DLY_W-1:0]         cfg_delay;
    logic [CHANNELS*BITS-1:0] d;
    logic [CHANNELS*BITS-1:0] q;
    logic [CHANNELS-1:0]      q_valid;
    logic                     cfg_err;

    modport master (
        output en, clr, cfg_we, cfg_ch, cfg_delay, d,
        input  q, q_valid, cfg_err
    );

    modport slave (
        input  en, clr, cfg_we, cfg_ch, cfg_delay, d,
        output q, q_valid, cfg_err
    );
endinterface

// File: rtl/skew_delay_bank.sv
// Multi-lane programmable delay bank sharing one shift enable and write pointer;
// generates the diagonal input skew in front of the systolic array.
module skew_delay_bank #(
    parameter int DEPTH    = 8,
    parameter int BITS     = 64,
    parameter int CHANNELS = 8
) (
    input logic            clk,
    input logic            rst_n,
    skew_delay_bank_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DLY_W = $clog2(DEPTH + 1);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SUM_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [DLY_W-1:0] FULL     = DLY_W'(DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);

    logic [BITS-1:0]  mem    [CHANNELS][DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [DLY_W-1:0] dly    [CHANNELS];
    logic [DLY_W-1:0] fill   [CHANNELS];
    logic [SUM_W-1:0] rd_sum [CHANNELS];
    logic [PTR_W-1:0] rd     [CHANNELS];
    logic             cfg_ok;
    logic             active;
    logic             cfg_err_q;

    assign cfg_ok      = (int'(bus.cfg_ch) < CHANNELS) && (int'(bus.cfg_delay) <= DEPTH);
    assign active      = rst_n & bus.en & ~bus.clr;
    assign bus.cfg_err = cfg_err_q;

    // The extra pointer bit keeps wptr + DEPTH - dly from underflowing before the wrap.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            rd_sum[c] = SUM_W'(wptr) + DEPTH_S - SUM_W'(dly[c]);
            rd[c]     = (rd_sum[c] >= DEPTH_S) ? PTR_W'(rd_sum[c] - DEPTH_S)
                                               : PTR_W'(rd_sum[c]);
        end
    end

    always_comb begin
        bus.q       = '0;
        bus.q_valid = '0;
        if (active) begin
            for (int c = 0; c < CHANNELS; c++) begin
                bus.q_valid[c] = (fill[c] >= dly[c]);
                bus.q[c*BITS +: BITS] = (dly[c] == '0) ? bus.d[c*BITS +: BITS]
                                                       : mem[c][rd[c]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
            end
        end else if (bus.clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
            end
        end else if (bus.en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[c][wptr] <= bus.d[c*BITS +: BITS];
            end
        end
    end

    // A legal configuration write lands after the shift/flush update so the lane's fill restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            cfg_err_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill[c] <= '0;
                dly[c]  <= (c < DEPTH) ? DLY_W'(c) : FULL;
            end
        end else begin
            cfg_err_q <= bus.cfg_we & ~cfg_ok;
            if (bus.clr) begin
                wptr <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    fill[c] <= '0;
                end
            end else if (bus.en) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + PTR_W'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    fill[c] <= (fill[c] == FULL) ? FULL : fill[c] + DLY_W'(1);
                end
            end
            if (bus.cfg_we && cfg_ok) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (CH_W'(c) == bus.cfg_ch) begin
                        dly[c]  <= bus.cfg_delay;
                        fill[c] <= '0;
                    end
                end
            end
        end
    end
endmodule
